acc_requant: RTL and testbench

Output-side consumer of the `mac8` accumulator array. It reads signed 32-bit accumulators, together with their overflow flags, over a valid/ready stream. Each value is scaled by a fixed-point multiplier, rounded, offset by a zero-point, optionally ReLU-clamped and saturated to signed int8. The block sits between the PE array drain path and the activation buffer writer, converting layer results back to the int8 domain the MACs consume.

---
 rtl/acc_requant.sv | 130 +++++++++++++
 tb/tb_acc_requant.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_requant.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | acc_requant: requantizes signed accumulators to saturated int8 through a   |
// | three-stage scale / round / zero-point pipeline with a clip counter.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module acc_requant #(
    parameter int ACC_W   = 32,
    parameter int SCALE_W = 16,
    parameter int SHIFT_W = 5,
    parameter int OUT_W   = 8,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [ACC_W-1:0]   in_acc,
    input  logic               in_sat,
    input  logic [SCALE_W-1:0] cfg_scale,
    input  logic [SHIFT_W-1:0] cfg_shift,
    input  logic [OUT_W-1:0]   cfg_zp,
    input  logic               cfg_relu,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OUT_W-1:0]   out_data,
    output logic               out_clip,
    output logic               busy,
    input  logic               cnt_clr,
    output logic [CNT_W-1:0]   clip_count
);

    localparam int c_prod_w = ACC_W + SCALE_W + 1;
    localparam logic signed [c_prod_w-1:0] c_out_max =
        {{(c_prod_w-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [c_prod_w-1:0] c_out_min =
        {{(c_prod_w-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    logic                       s1_valid_q, s2_valid_q, s3_valid_q;
    logic                       s1_sat_q, s2_sat_q;
    logic signed [c_prod_w-1:0] s1_p_q, s2_r_q;
    logic [OUT_W-1:0]           out_data_q;
    logic                       out_clip_q;
    logic [CNT_W-1:0]           clip_count_q, clip_count_d;

    logic                       w_adv;
    logic signed [c_prod_w-1:0] w_acc_ext, w_scale_ext, w_prod;
    logic signed [c_prod_w-1:0] w_round, w_sum, w_shr;
    logic signed [c_prod_w-1:0] w_zp_ext, w_v, w_v_relu;
    logic                       w_hi, w_lo, w_clip;
    logic [OUT_W-1:0]           w_data;

    // Whole pipeline moves in lockstep; bubbles are intentionally not squeezed out.
    assign w_adv    = !s3_valid_q || out_ready;
    assign in_ready = w_adv;

    // Both operands widened to the full product width so the truncated product is exact.
    assign w_acc_ext   = {{(SCALE_W+1){in_acc[ACC_W-1]}}, in_acc};
    assign w_scale_ext = {{(ACC_W+1){1'b0}}, cfg_scale};
    assign w_prod      = w_acc_ext * w_scale_ext;

    always_comb begin
        w_round = '0;
        if (cfg_shift != '0) begin
            w_round = {{(c_prod_w-1){1'b0}}, 1'b1} << (cfg_shift - SHIFT_W'(1));
        end
    end

    assign w_sum = s1_p_q + w_round;
    assign w_shr = w_sum >>> cfg_shift;

    assign w_zp_ext = {{(c_prod_w-OUT_W){cfg_zp[OUT_W-1]}}, cfg_zp};
    assign w_v      = s2_r_q + w_zp_ext;
    assign w_v_relu = (cfg_relu && (w_v < w_zp_ext)) ? w_zp_ext : w_v;
    assign w_hi     = w_v_relu > c_out_max;
    assign w_lo     = w_v_relu < c_out_min;
    assign w_clip   = s2_sat_q | w_hi | w_lo;
    assign w_data   = w_hi ? c_out_max[OUT_W-1:0] :
                      w_lo ? c_out_min[OUT_W-1:0] : w_v_relu[OUT_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s3_valid_q <= 1'b0;
            s1_sat_q   <= 1'b0;
            s2_sat_q   <= 1'b0;
            s1_p_q     <= '0;
            s2_r_q     <= '0;
            out_data_q <= '0;
            out_clip_q <= 1'b0;
        end else if (w_adv) begin
            s1_valid_q <= in_valid;
            s1_sat_q   <= in_sat;
            s1_p_q     <= w_prod;
            s2_valid_q <= s1_valid_q;
            s2_sat_q   <= s1_sat_q;
            s2_r_q     <= w_shr;
            s3_valid_q <= s2_valid_q;
            out_data_q <= w_data;
            out_clip_q <= w_clip;
        end
    end

    // Clear has priority; the count sticks at all-ones instead of wrapping.
    always_comb begin
        clip_count_d = clip_count_q;
        if (cnt_clr) begin
            clip_count_d = '0;
        end else if (s3_valid_q && out_ready && out_clip_q && (clip_count_q != '1)) begin
            clip_count_d = clip_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clip_count_q <= '0;
        end else begin
            clip_count_q <= clip_count_d;
        end
    end

    assign out_valid  = s3_valid_q;
    assign out_data   = out_data_q;
    assign out_clip   = out_clip_q;
    assign busy       = s1_valid_q | s2_valid_q | s3_valid_q;
    assign clip_count = clip_count_q;

endmodule
`default_nettype wire

// File: tb/tb_acc_requant.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_acc_requant: vector table plus scoreboard bench for acc_requant.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_acc_requant;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_sat;
    logic [31:0] in_acc;
    logic [15:0] cfg_scale;
    logic [4:0]  cfg_shift;
    logic [7:0]  cfg_zp;
    logic        cfg_relu;
    logic        out_valid, out_ready, out_clip, busy, cnt_clr;
    logic [7:0]  out_data;
    logic [15:0] clip_count;

    acc_requant dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_acc(in_acc), .in_sat(in_sat),
        .cfg_scale(cfg_scale), .cfg_shift(cfg_shift), .cfg_zp(cfg_zp), .cfg_relu(cfg_relu),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_clip(out_clip),
        .busy(busy), .cnt_clr(cnt_clr), .clip_count(clip_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int delivered = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] data;
        logic       clip;
        int         edge_n;
        logic       chk_lat;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [15:0] scale;
        logic [4:0]  shift;
        logic [7:0]  zp;
        logic        relu;
        logic [31:0] acc;
        logic        sat;
        logic [7:0]  ed;
        logic        ec;
    } vec_t;
    vec_t vt[15];

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model(input longint acc, input longint scale, input int shift,
                                  input longint zp, input bit relu, input bit sat,
                                  output logic [7:0] d, output logic c);
        longint p, v;
        p = acc * scale;
        if (shift > 0) p = p + (longint'(1) <<< (shift - 1));
        v = (p >>> shift) + zp;
        if (relu && v < zp) v = zp;
        c = sat || (v > 127) || (v < -128);
        if (v > 127) v = 127;
        else if (v < -128) v = -128;
        d = v[7:0];
    endfunction

    // Output monitor: pops the scoreboard on each handshake and checks held outputs.
    exp_t       me;
    logic       held_v = 1'b0;
    logic [7:0] held_d;
    logic       held_c;
    always @(negedge clk) begin
        if (rst) begin
            held_v = 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                delivered++;
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_output: got data=%0d with nothing expected", $signed(out_data));
                end else begin
                    me = sb.pop_front();
                    check("out_data", $signed(out_data), $signed(me.data));
                    check("out_clip", out_clip, me.clip);
                    if (me.chk_lat) check("latency", cyc - me.edge_n, 3);
                end
            end
            if (out_valid && !out_ready) begin
                if (held_v) begin
                    check("hold_data", out_data, held_d);
                    check("hold_clip", out_clip, held_c);
                end
                held_v = 1'b1;
                held_d = out_data;
                held_c = out_clip;
            end else begin
                held_v = 1'b0;
            end
        end
    end

    // Called and returns at posedge+1; pushes the expectation at the accepting handshake.
    task automatic send(input logic [31:0] acc, input logic sat, input logic [7:0] ed,
                        input logic ec, input logic lat);
        exp_t e;
        bit   done = 1'b0;
        in_acc   = acc;
        in_sat   = sat;
        in_valid = 1'b1;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            if (in_ready) begin
                e.data = ed; e.clip = ec; e.edge_n = cyc; e.chk_lat = lat;
                sb.push_back(e);
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!done) begin
            total++; bad++;
            $display("FAIL send_timeout: got in_ready=0 for 200 cycles expected 1");
        end
    endtask

    task automatic wait_idle();
        bit idle = 1'b0;
        for (int k = 0; k < 200 && !idle; k++) begin
            @(negedge clk);
            if (!busy) idle = 1'b1;
        end
        if (!idle) begin
            total++; bad++;
            $display("FAIL idle_timeout: got busy=1 for 200 cycles expected 0");
        end
        @(posedge clk); #1;
    endtask

    int          acc_stall;
    int          dlv0;
    int          clipped;
    logic [7:0]  md;
    logic        mc;
    bit          seen;

    initial begin
        vt[0]  = '{16'd8192,  5'd16, 8'd0,  1'b0, 32'd1000,       1'b0, 8'd125, 1'b0};
        vt[1]  = '{16'd1,     5'd1,  8'd0,  1'b0, 32'd3,          1'b0, 8'd2,   1'b0};
        vt[2]  = '{16'd1,     5'd1,  8'd0,  1'b0, 32'hFFFF_FFFD,  1'b0, 8'hFF,  1'b0};
        vt[3]  = '{16'd1,     5'd1,  8'd0,  1'b0, 32'd5,          1'b0, 8'd3,   1'b0};
        vt[4]  = '{16'd1,     5'd0,  8'd0,  1'b0, 32'd1000,       1'b0, 8'd127, 1'b1};
        vt[5]  = '{16'd1,     5'd0,  8'd0,  1'b0, 32'hFFFF_FF38,  1'b0, 8'h80,  1'b1};
        vt[6]  = '{16'd1,     5'd0,  8'hEC, 1'b0, 32'd100,        1'b0, 8'd80,  1'b0};
        vt[7]  = '{16'd1,     5'd0,  8'd0,  1'b0, 32'd0,          1'b1, 8'd0,   1'b1};
        vt[8]  = '{16'd1,     5'd0,  8'd10, 1'b1, 32'hFFFF_FFCE,  1'b0, 8'd10,  1'b0};
        vt[9]  = '{16'd1,     5'd0,  8'd10, 1'b0, 32'hFFFF_FFCE,  1'b0, 8'hD8,  1'b0};
        vt[10] = '{16'd65535, 5'd31, 8'd0,  1'b0, 32'h8000_0000,  1'b0, 8'h80,  1'b1};
        vt[11] = '{16'd1,     5'd0,  8'd10, 1'b1, 32'd200,        1'b0, 8'd127, 1'b1};
        vt[12] = '{16'd1,     5'd1,  8'd0,  1'b0, 32'hFFFF_FFFF,  1'b0, 8'd0,   1'b0};
        vt[13] = '{16'd1,     5'd0,  8'd0,  1'b0, 32'hFFFF_FF80,  1'b0, 8'h80,  1'b0};
        vt[14] = '{16'd1,     5'd0,  8'd0,  1'b0, 32'd127,        1'b0, 8'd127, 1'b0};

        rst = 1'b1; in_valid = 1'b0; in_acc = '0; in_sat = 1'b0;
        cfg_scale = 16'd1; cfg_shift = '0; cfg_zp = '0; cfg_relu = 1'b0;
        out_ready = 1'b1; cnt_clr = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_clip", out_clip, 0);
        check("rst_clip_count", clip_count, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_in_ready", in_ready, 1);

        clipped = 0;
        for (int i = 0; i < 15; i++) begin
            cfg_scale = vt[i].scale; cfg_shift = vt[i].shift;
            cfg_zp = vt[i].zp; cfg_relu = vt[i].relu;
            send(vt[i].acc, vt[i].sat, vt[i].ed, vt[i].ec, 1'b1);
            wait_idle();
            if (vt[i].ec) clipped++;
        end

        // Stall from an empty pipeline: exactly three words fit before in_ready drops.
        cfg_scale = 16'd1; cfg_shift = '0; cfg_zp = '0; cfg_relu = 1'b0;
        dlv0 = delivered;
        acc_stall = 0;
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    int a;
                    a = i * 40 - 150;
                    model(longint'(a), 1, 0, 0, 1'b0, 1'b0, md, mc);
                    if (mc) clipped++;
                    send(a, 1'b0, md, mc, 1'b0);
                end
            end
            begin
                repeat (5) begin
                    @(negedge clk);
                    if (in_valid && in_ready) acc_stall++;
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        wait_idle();
        check("stall_accepts", acc_stall, 3);
        check("stream_delivered", delivered - dlv0, 8);
        check("clip_count_total", clip_count, clipped);

        cnt_clr = 1'b1;
        @(posedge clk); #1;
        cnt_clr = 1'b0;
        check("clip_count_cleared", clip_count, 0);
        for (int i = 0; i < 3; i++) send(32'd1000, 1'b0, 8'd127, 1'b1, 1'b1);
        wait_idle();
        check("clip_count_three", clip_count, 3);

        // Clear lands on the same edge as a clipped handshake.
        out_ready = 1'b0;
        send(32'd1000, 1'b0, 8'd127, 1'b1, 1'b0);
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("clr_word_arrived", seen, 1);
        @(posedge clk); #1;
        cnt_clr = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        cnt_clr = 1'b0;
        check("clr_beats_increment", clip_count, 0);
        wait_idle();

        // Reset with all three stages occupied.
        out_ready = 1'b0;
        send(32'd1, 1'b0, 8'd1, 1'b0, 1'b0);
        send(32'd2, 1'b0, 8'd2, 1'b0, 1'b0);
        send(32'd3, 1'b0, 8'd3, 1'b0, 1'b0);
        check("full_busy", busy, 1);
        check("full_out_valid", out_valid, 1);
        check("full_in_ready", in_ready, 0);
        #2 rst = 1'b1;
        #1;
        check("async_rst_out_valid", out_valid, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_in_ready", in_ready, 1);
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        dlv0 = delivered;
        repeat (6) @(negedge clk);
        check("no_stale_output", delivered - dlv0, 0);
        check("post_rst_busy", busy, 0);
        check("scoreboard_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
